// File: rtl/accel_move_gen.sv
// Accelerometer tilt to one-hot ball movement command generator.
// Averages samples, applies dead-zone hysteresis, picks the dominant axis and paces output on an update square wave.
module accel_move_gen #(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 30,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5,
  parameter int CNTR_WIDTH             = 32,
  parameter int SAMPLE_WIDTH           = 12,
  parameter int AVG_LOG2               = 2,
  parameter int THRESH_ON              = 200,
  parameter int THRESH_OFF             = 120,
  parameter int THRESH_FAST            = 600
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] accel_x,
  input  logic signed [SAMPLE_WIDTH-1:0] accel_y,
  input  logic                           accel_valid,
  output logic [3:0]                     movement,
  output logic                           update,
  output logic                           avg_ready
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int AW = SAMPLE_WIDTH + AVG_LOG2;
  localparam int MW = SAMPLE_WIDTH + 1;
  localparam int CW = AVG_LOG2 + 1;

  localparam logic [CNTR_WIDTH-1:0] TC = CNTR_WIDTH'((SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                   : CLK_FREQUENCY_HZ / (2 * UPDATE_FREQUENCY_HZ) - 1);
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  localparam logic [MW-1:0] TH_ON   = MW'(THRESH_ON);
  localparam logic [MW-1:0] TH_OFF  = MW'(THRESH_OFF);
  localparam logic [MW-1:0] TH_FAST = MW'(THRESH_FAST);

  localparam logic [3:0] MOV_IDLE  = 4'b0000;
  localparam logic [3:0] MOV_UP    = 4'b0001;
  localparam logic [3:0] MOV_DOWN  = 4'b0010;
  localparam logic [3:0] MOV_LEFT  = 4'b0100;
  localparam logic [3:0] MOV_RIGHT = 4'b1000;

  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  update_q, update_d;
  logic signed [AW-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CW-1:0]         count_q, count_d;
  logic signed [SW-1:0]  avg_x_q, avg_x_d, avg_y_q, avg_y_d;
  logic                  act_x_q, act_x_d, act_y_q, act_y_d;
  logic                  avg_ready_q, avg_ready_d;
  logic [3:0]            movement_q, movement_d;
  logic                  phase_q, phase_d;

  logic                  wrap, fall;
  logic signed [AW-1:0]  sum_x, sum_y;
  logic [MW-1:0]         mag_x, mag_y, sel_mag;
  logic [3:0]            dir;
  logic                  use_x;

  // Widened by one bit so the most negative sample has a representable magnitude.
  function automatic logic [MW-1:0] abs_mag(input logic signed [SW-1:0] v);
    logic signed [MW-1:0] e;
    e = MW'(v);
    return e[MW-1] ? $unsigned(-e) : $unsigned(e);
  endfunction

  function automatic logic next_active(input logic act, input logic [MW-1:0] mag);
    if (!act) return (mag > TH_ON);
    return !(mag < TH_OFF);
  endfunction

  always_comb begin
    cnt_d       = cnt_q;
    update_d    = update_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    count_d     = count_q;
    avg_x_d     = avg_x_q;
    avg_y_d     = avg_y_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    avg_ready_d = 1'b0;
    movement_d  = movement_q;
    phase_d     = phase_q;

    wrap = (cnt_q == TC);
    fall = wrap && update_q;
    if (wrap) begin
      cnt_d    = '0;
      update_d = ~update_q;
    end else begin
      cnt_d = cnt_q + CNTR_WIDTH'(1);
    end

    sum_x = acc_x_q + AW'(accel_x);
    sum_y = acc_y_q + AW'(accel_y);
    if (accel_valid) begin
      if (count_q == LAST) begin
        avg_x_d     = SW'(sum_x >>> AVG_LOG2);
        avg_y_d     = SW'(sum_y >>> AVG_LOG2);
        act_x_d     = next_active(act_x_q, abs_mag(SW'(sum_x >>> AVG_LOG2)));
        act_y_d     = next_active(act_y_q, abs_mag(SW'(sum_y >>> AVG_LOG2)));
        acc_x_d     = '0;
        acc_y_d     = '0;
        count_d     = '0;
        avg_ready_d = 1'b1;
      end else begin
        acc_x_d = sum_x;
        acc_y_d = sum_y;
        count_d = count_q + CW'(1);
      end
    end

    // Selection uses registered flags, so an average latched on the falling edge waits a period.
    mag_x   = abs_mag(avg_x_q);
    mag_y   = abs_mag(avg_y_q);
    use_x   = act_x_q && (!act_y_q || (mag_x >= mag_y));
    sel_mag = use_x ? mag_x : mag_y;
    if (use_x) dir = avg_x_q[SW-1] ? MOV_LEFT : MOV_RIGHT;
    else       dir = avg_y_q[SW-1] ? MOV_DOWN : MOV_UP;

    if (fall) begin
      if (!act_x_q && !act_y_q) begin
        movement_d = MOV_IDLE;
        phase_d    = 1'b0;
      end else if (sel_mag >= TH_FAST) begin
        movement_d = dir;
        phase_d    = 1'b0;
      end else begin
        movement_d = phase_q ? MOV_IDLE : dir;
        phase_d    = ~phase_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      update_q    <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      count_q     <= '0;
      avg_x_q     <= '0;
      avg_y_q     <= '0;
      act_x_q     <= 1'b0;
      act_y_q     <= 1'b0;
      avg_ready_q <= 1'b0;
      movement_q  <= MOV_IDLE;
      phase_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      update_q    <= update_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      count_q     <= count_d;
      avg_x_q     <= avg_x_d;
      avg_y_q     <= avg_y_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      avg_ready_q <= avg_ready_d;
      movement_q  <= movement_d;
      phase_q     <= phase_d;
    end
  end

  assign movement  = movement_q;
  assign update    = update_q;
  assign avg_ready = avg_ready_q;

endmodule

// File: tb/tb_accel_move_gen.sv
// Directed bench for accel_move_gen with the fast simulation prescaler (TC=5, update period 12 cycles).
module tb_accel_move_gen;

  logic                    clk;
  logic                    reset;
  logic signed [11:0]      accel_x;
  logic signed [11:0]      accel_y;
  logic                    accel_valid;
  logic [3:0]              movement;
  logic                    update;
  logic                    avg_ready;

  int passes = 0;
  int total  = 0;

  accel_move_gen #(
    .SIMULATE(1),
    .SIMULATE_FREQUENCY_CNT(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .accel_x(accel_x),
    .accel_y(accel_y),
    .accel_valid(accel_valid),
    .movement(movement),
    .update(update),
    .avg_ready(avg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Four back-to-back samples starting at the current negedge; avg_ready is seen one cycle after the last.
  task automatic applyStimulus(input int x, input int y);
    accel_x     = 12'(x);
    accel_y     = 12'(y);
    accel_valid = 1'b1;
    repeat (4) @(negedge clk);
    accel_valid = 1'b0;
    checkOutput("avg_ready_pulse", {31'd0, avg_ready}, 32'd1);
    @(negedge clk);
    checkOutput("avg_ready_low", {31'd0, avg_ready}, 32'd0);
  endtask

  task automatic waitFall(output bit ok);
    bit prev;
    prev = update;
    ok   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev && !update) begin
        ok = 1'b1;
        break;
      end
      prev = update;
    end
  endtask

  task automatic fallCheck(input string tag, input logic [3:0] exp);
    bit ok;
    waitFall(ok);
    checkOutput({tag, "_edge_seen"}, {31'd0, ok}, 32'd1);
    checkOutput(tag, {28'd0, movement}, {28'd0, exp});
  endtask

  initial begin
    int rise_at;
    int period;
    bit prev;
    bit ok;

    reset       = 1'b0;
    accel_x     = '0;
    accel_y     = '0;
    accel_valid = 1'b0;

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_movement", {28'd0, movement}, 32'd0);
      checkOutput("reset_update", {31'd0, update}, 32'd0);
      checkOutput("reset_avg_ready", {31'd0, avg_ready}, 32'd0);
    end
    reset = 1'b1;

    rise_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (update) begin
        rise_at = i;
        break;
      end
    end
    checkOutput("first_rise_cycles", 32'(rise_at), 32'd6);

    period = -1;
    prev   = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!prev && update) begin
        period = i;
        break;
      end
      prev = update;
    end
    checkOutput("update_period", 32'(period), 32'd12);
    checkOutput("idle_movement", {28'd0, movement}, 32'd0);

    // Slow mode: emit, skip, emit.
    waitFall(ok);
    checkOutput("sync_edge_seen", {31'd0, ok}, 32'd1);
    applyStimulus(300, 0);
    fallCheck("slow_right_1", 4'b1000);
    fallCheck("slow_right_2", 4'b0000);
    fallCheck("slow_right_3", 4'b1000);

    applyStimulus(700, 0);
    fallCheck("fast_right_1", 4'b1000);
    fallCheck("fast_right_2", 4'b1000);

    // Hysteresis: 150 keeps the axis, 100 drops it.
    applyStimulus(150, 0);
    fallCheck("hyst_hold_1", 4'b1000);
    fallCheck("hyst_hold_2", 4'b0000);
    applyStimulus(100, 0);
    fallCheck("hyst_release", 4'b0000);

    applyStimulus(-250, 400);
    fallCheck("y_dominant_up", 4'b0001);
    applyStimulus(-300, 300);
    fallCheck("tie_skip", 4'b0000);
    fallCheck("tie_left", 4'b0100);

    applyStimulus(700, 0);
    fallCheck("pre_reset_right", 4'b1000);

    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (update) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("pre_reset_update_high", {31'd0, ok}, 32'd1);
    checkOutput("pre_reset_movement", {28'd0, movement}, 32'd8);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_movement", {28'd0, movement}, 32'd0);
    checkOutput("async_reset_update", {31'd0, update}, 32'd0);
    checkOutput("async_reset_avg_ready", {31'd0, avg_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Most negative sample: magnitude 2048 must not wrap.
    applyStimulus(-2048, 0);
    fallCheck("min_left_1", 4'b0100);
    fallCheck("min_left_2", 4'b0100);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
